uart_tx_arb: RTL
================

// Module: uart_tx_arb
// PURPOSE
//  Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
//  - Accepts one byte per grant over a valid/ready handshake.
//  - Holds the byte in an internal buffer and issues a one-cycle tx_start pulse.
//  - Waits for tx_done, then re-arbitrates.
//  - Sits between on-chip producers (CPU MMIO, debug, DMA) and the UART TX shifter.
// PARAMETERS
//  NUM_REQ     4  number of requesters (>=2)
//  WORD_WIDTH  8  bits per UART character
//  GRANT_W     $clog2(NUM_REQ)  width of grant index (derived, localparam)
// PORTS
//  clk         in   1                   system clock, all logic on rising edge
//  rst_n       in   1                   asynchronous active-low reset
//  req_valid   in   NUM_REQ             per-requester byte valid
//  req_data    in   NUM_REQ*WORD_WIDTH  requester i data at [i*WORD_WIDTH +: WORD_WIDTH]
//  req_last    in   NUM_REQ             end-of-packet marker (present only with UART_TX_ARB_LOCK_EN)
//  req_ready   out  NUM_REQ             one-hot accept strobe; transfer when valid&ready
//  tx_start    out  1                   one-cycle pulse to transmitter: load tx_data
//  tx_data     out  WORD_WIDTH          byte to transmit, stable from tx_start until tx_done
//  tx_done     in   1                   one-cycle pulse from transmitter: character finished
//  grant_id    out  GRANT_W             index of requester owning current/last byte
//  busy        out  1                   high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0, rr pointer=0.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: if any req_valid, pick first valid index searching from (grant_id+1) mod NUM_REQ
//     upward with wrap-around; fewer than NUM_REQ entries searched only by wrap order.
//     - req_ready[pick] driven combinationally high in the same cycle (others 0).
//     - On that edge: latch data to tx_data, grant_id<=pick, go ISSUE.
//     - No valid: stay IDLE, req_ready=0.
//   ISSUE: tx_start=1 for exactly this cycle; go WAIT. tx_done sampled here is ignored.
//   WAIT: hold tx_data; on tx_done go IDLE. No timeout.
//  req_ready is 0 in ISSUE and WAIT; a requester must hold valid/data until accepted.
//  Latency: accept at cycle N -> tx_start at N+1. After tx_done at cycle M, next accept
//   is possible at M+1 (IDLE).
//  tx_done in IDLE or ISSUE: ignored, no state change.
//  Fairness: a requester continuously valid waits at most NUM_REQ-1 other bytes.
//  Single requester active: it is re-granted every byte; the pointer still advances.
//  Valid dropped before accept: no penalty, no side effect.
//  Reset mid-operation (ISSUE/WAIT): abort to IDLE; the held byte is discarded and
//   tx_start is never re-issued.
// CONFIGURATION
//  UART_TX_ARB_LOCK_EN defined:
//   - req_last port exists.
//   - Accepting a byte with req_last=0 locks the grant to grant_id.
//   - While locked, IDLE considers only req_valid[grant_id]; others see ready=0.
//   - Accepting a byte with req_last=1 unlocks. Reset unlocks.
//  UART_TX_ARB_LOCK_EN undefined: no req_last port; every byte re-arbitrates independently.
// STRUCTURE
//  uart_pkg: FSM state encoding (IDLE/ISSUE/WAIT localparams), default WORD_WIDTH.
//  Sub-module rr_pick: combinational round-robin priority encoder
//   (in: vector, base index; out: onehot, index, any). Everything else stays in uart_tx_arb.
// TESTING
//  1. Reset, no valids -> req_ready=0, tx_start never pulses, busy=0, grant_id=0.
//  2. req_valid=0b0100, data2=0xA5 -> ready[2] same cycle, tx_start next cycle,
//     tx_data=0xA5, grant_id=2; tx_done after 10 cycles -> busy=0 next cycle.
//  3. All four valid continuously, data i=0x10+i -> bytes sent in order 0x11,0x12,0x13,0x10,0x11.
//  4. tx_done pulsed in IDLE and in the ISSUE cycle -> ignored; FSM stays in WAIT
//     until a later tx_done.
//  5. rst_n low during WAIT -> all outputs to reset values within the same cycle;
//     no spurious tx_start after release.
//  6. LOCK_EN: req0 sends 3 bytes, last=0,0,1, req1 valid throughout -> 3 req0 bytes
//     sent back-to-back, then req1.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   state_t             : arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   DEFAULT_NUM_REQ     : default number of byte sources
//   DEFAULT_WORD_WIDTH  : default bits per UART character
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_WORD_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Returns the first set bit of
// vec found when scanning upward from index base, wrapping past N-1 to 0.
// Ports:
//   vec     in  N    request vector
//   base    in  IW   index that has highest priority this cycle (< N)
//   onehot  out N    one-hot of the selected index (all zero if none)
//   idx     out IW   selected index (0 if none)
//   any     out 1    at least one bit of vec is set
// ---------------------------------------------------------------------------
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = DEFAULT_NUM_REQ,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    pos    = 0;
    any    = |vec;
    // Scan from the farthest offset down to offset 0 so the nearest set bit
    // to base is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(base) + k;
      if (pos >= N) pos = pos - N;
      if (vec[pos]) idx = IW'(pos);
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources. In IDLE one valid source is accepted (req_ready high that same
// cycle), its byte is latched into tx_data, tx_start pulses for one cycle,
// and the arbiter then waits for tx_done before arbitrating again.
//
// Optional feature (macro UART_TX_ARB_LOCK_EN): adds the req_last port.
// Accepting a byte with req_last=0 locks the grant to that source until a
// byte with req_last=1 is accepted, so packets go out uninterrupted.
//
// Ports:
//   clk        in   1                   rising-edge clock
//   rst_n      in   1                   asynchronous active-low reset
//   req_valid  in   NUM_REQ             per-source byte valid
//   req_data   in   NUM_REQ*WORD_WIDTH  source i at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_last   in   NUM_REQ             end-of-packet (UART_TX_ARB_LOCK_EN only)
//   req_ready  out  NUM_REQ             one-hot accept strobe (combinational)
//   tx_start   out  1                   one-cycle load pulse to transmitter
//   tx_data    out  WORD_WIDTH          byte held from tx_start until tx_done
//   tx_done    in   1                   character-finished pulse
//   grant_id   out  GRANT_W             source owning the current/last byte
//   busy       out  1                   high whenever not IDLE
// ---------------------------------------------------------------------------
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter  int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  localparam int GRANT_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [WORD_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy
);

  state_t               state;
  logic [GRANT_W-1:0]   base;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_any;
  logic [WORD_WIDTH-1:0] pick_data;

`ifdef UART_TX_ARB_LOCK_EN
  logic locked;
`endif

  // Search starts just after the previous owner, wrapping for any NUM_REQ.
  always_comb begin
    if (grant_id == GRANT_W'(NUM_REQ - 1)) base = '0;
    else                                   base = grant_id + GRANT_W'(1);
  end

  // While a packet is locked only its owner may compete; with a single
  // candidate bit the search base is irrelevant.
  always_comb begin
`ifdef UART_TX_ARB_LOCK_EN
    if (locked) cand = req_valid & (NUM_REQ'(1) << grant_id);
    else        cand = req_valid;
`else
    cand = req_valid;
`endif
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (GRANT_W)
  ) u_rr_pick (
    .vec    (cand),
    .base   (base),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    pick_data = req_data[pick_idx*WORD_WIDTH +: WORD_WIDTH];
  end

  // Gated by rst_n so no source sees an accept while reset is asserted.
  always_comb begin
    if (rst_n && (state == S_IDLE)) req_ready = pick_onehot;
    else                            req_ready = '0;
  end

  // Arbiter FSM: IDLE -> ISSUE -> WAIT -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      locked   <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            tx_data  <= pick_data;
            grant_id <= pick_idx;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            locked   <= ~req_last[pick_idx];
`endif
          end
        end
        // tx_done here belongs to no character of ours and is ignored.
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
